// File: rtl/afifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the async FIFO write port.
// The master drives requests and the FIFO full flag; the arbiter is the slave.
interface afifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ-1:0][WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]            req_last_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic                        fifo_wr_en_o;
  logic [ID_W+WIDTH-1:0]       fifo_wr_data_o;
  logic                        fifo_full_i;

  modport master (
    output req_valid_i, req_data_i, req_last_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_wr_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_wr_data_o
  );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one async FIFO write port; each beat is tagged
// with its source ID.
//   state  | meaning
//   IDLE   | no owner; the round-robin winner may write this cycle
//   LOCKED | owner holds the port until its last beat or the burst limit
module afifo_wr_arbiter #(
  parameter int  N_REQ     = 4,
  parameter int  WIDTH     = 8,
  parameter int  MAX_BURST = 0,
  localparam int ID_W      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk_wr,
  input  logic                  arst_wr,
  afifo_wr_arbiter_if.slave     bus,
  output logic [ID_W-1:0]       grant_id_o,
  output logic                  busy_o,
  output logic [15:0]           pkt_cnt_o
);

  localparam int BC_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] owner, rr_ptr, winner, sel;
  logic [ID_W:0]   scan_idx;
  logic            win_valid, grant_ok, sel_last, fire, burst_end;
  logic [BC_W-1:0] beat_cnt;
  logic [BC_W:0]   beat_inc;

  // Explicit wrap so non-power-of-2 N_REQ never lands on an unused index.
  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(N_REQ - 1)) ? '0 : p + ID_W'(1);
  endfunction

  // Scan from the far end so the lowest offset from rr_ptr is the last writer and wins.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(N_REQ)) scan_idx = scan_idx - (ID_W+1)'(N_REQ);
      if (bus.req_valid_i[scan_idx[ID_W-1:0]]) begin
        win_valid = 1'b1;
        winner    = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel       = (state == LOCKED) ? owner : winner;
    grant_ok  = (state == LOCKED) || win_valid;
    sel_last  = bus.req_last_i[sel];
    beat_inc  = {1'b0, beat_cnt} + (BC_W+1)'(1);
    burst_end = (MAX_BURST != 0) && (beat_inc == (BC_W+1)'(MAX_BURST));
  end

  always_ff @(posedge clk_wr or posedge arst_wr) begin
    if (arst_wr) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire && !sel_last) state_nxt = LOCKED;
      LOCKED:  if (fire && (sel_last || burst_end)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready and write enable are combinational from fifo_full_i; reset forces them low.
  always_comb begin
    bus.req_ready_o = '0;
    if (grant_ok && !bus.fifo_full_i && !arst_wr) bus.req_ready_o[sel] = 1'b1;
    fire               = grant_ok && bus.req_valid_i[sel] && !bus.fifo_full_i && !arst_wr;
    bus.fifo_wr_en_o   = fire;
    bus.fifo_wr_data_o = {sel, bus.req_data_i[sel]};
  end

  assign busy_o = (state == LOCKED);

  always_ff @(posedge clk_wr or posedge arst_wr) begin
    if (arst_wr) begin
      owner      <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id_o <= '0;
      pkt_cnt_o  <= '0;
    end else if (fire) begin
      if (state == IDLE) begin
        grant_id_o <= winner;
        if (sel_last) begin
          rr_ptr    <= ptr_inc(winner);
          pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end else begin
          owner    <= winner;
          beat_cnt <= BC_W'(1);
        end
      end else begin
        if (sel_last) begin
          rr_ptr    <= ptr_inc(owner);
          pkt_cnt_o <= pkt_cnt_o + 16'd1;
        end else if (burst_end) begin
          // Forced release: the rest of the packet re-arbitrates like a new request.
          rr_ptr <= ptr_inc(owner);
        end else begin
          beat_cnt <= beat_inc[BC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter: unlimited-burst instance and a MAX_BURST=2 instance
// sharing clock and reset.
module tb_afifo_wr_arbiter;
  logic        clk_wr = 1'b0;
  logic        arst_wr = 1'b0;
  logic [1:0]  grant0, grant1;
  logic        busy0, busy1;
  logic [15:0] pkt0, pkt1;
  int          errors = 0;
  int          checks = 0;

  afifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8), .ID_W(2)) b0 ();
  afifo_wr_arbiter_if #(.N_REQ(4), .WIDTH(8), .ID_W(2)) b1 ();

  afifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(0)) dut0 (
    .clk_wr(clk_wr), .arst_wr(arst_wr), .bus(b0.slave),
    .grant_id_o(grant0), .busy_o(busy0), .pkt_cnt_o(pkt0)
  );

  afifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(2)) dut1 (
    .clk_wr(clk_wr), .arst_wr(arst_wr), .bus(b1.slave),
    .grant_id_o(grant1), .busy_o(busy1), .pkt_cnt_o(pkt1)
  );

  always #5 clk_wr = ~clk_wr;

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    arst_wr = 1'b1;
    b0.req_valid_i = 4'b1111;
    b0.req_last_i  = 4'b1111;
    #2;
    checks++; if (b0.req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", b0.req_ready_o); end
    checks++; if (b0.fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", b0.fifo_wr_en_o); end
    checks++; if (busy0 !== 1'b0 || grant0 !== 2'd0) begin errors++; $display("FAIL reset_busy_grant got=%b/%0d exp=0/0", busy0, grant0); end
    checks++; if (pkt0 !== 16'd0 || pkt1 !== 16'd0) begin errors++; $display("FAIL reset_pkt got=%0d/%0d exp=0/0", pkt0, pkt1); end
    repeat (2) step();
    arst_wr = 1'b0;
    b0.req_valid_i = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_wr);
      checks++; if (b0.fifo_wr_en_o !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL idle_quiet got=%b/%b exp=0/0", b0.fifo_wr_en_o, busy0); end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [9:0] exp;
    b0.req_valid_i = 4'b1111;
    b0.req_last_i  = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 4; i++) b0.req_data_i[i] = {4'(i), 4'(c)};
      exp = {2'(c % 4), 4'(c % 4), 4'(c)};
      @(negedge clk_wr);
      checks++; if (b0.fifo_wr_en_o !== 1'b1 || b0.fifo_wr_data_o !== exp) begin errors++; $display("FAIL rr_beat%0d got=%b/%h exp=1/%h", c, b0.fifo_wr_en_o, b0.fifo_wr_data_o, exp); end
      if (c == 0) begin
        checks++; if (b0.req_ready_o !== 4'b0001) begin errors++; $display("FAIL rr_ready got=%b exp=0001", b0.req_ready_o); end
      end
      step();
    end
    b0.req_valid_i = 4'b0000;
    checks++; if (pkt0 !== 16'd8 || grant0 !== 2'd3) begin errors++; $display("FAIL rr_pkt_grant got=%0d/%0d exp=8/3", pkt0, grant0); end
  endtask

  task automatic test_locked();
    logic [9:0] exp;
    b0.req_valid_i   = 4'b0110;
    b0.req_last_i    = 4'b0100;
    b0.req_data_i[2] = 8'h22;
    for (int b = 0; b < 3; b++) begin
      b0.req_data_i[1] = 8'(160 + b);
      b0.req_last_i[1] = (b == 2);
      exp = {2'd1, 8'(160 + b)};
      @(negedge clk_wr);
      checks++; if (b0.fifo_wr_en_o !== 1'b1 || b0.fifo_wr_data_o !== exp) begin errors++; $display("FAIL lock_beat%0d got=%b/%h exp=1/%h", b, b0.fifo_wr_en_o, b0.fifo_wr_data_o, exp); end
      checks++; if (b0.req_ready_o[2] !== 1'b0 || busy0 !== (b != 0)) begin errors++; $display("FAIL lock_ready2_busy%0d got=%b/%b exp=0/%b", b, b0.req_ready_o[2], busy0, (b != 0)); end
      step();
    end
    b0.req_valid_i = 4'b0100;
    @(negedge clk_wr);
    checks++; if (busy0 !== 1'b0 || b0.fifo_wr_data_o !== {2'd2, 8'h22} || b0.fifo_wr_en_o !== 1'b1) begin errors++; $display("FAIL lock_next_req2 got=%b/%b/%h exp=0/1/222", busy0, b0.fifo_wr_en_o, b0.fifo_wr_data_o); end
    step();
    b0.req_valid_i = 4'b0000;
    checks++; if (pkt0 !== 16'd10) begin errors++; $display("FAIL lock_pkt got=%0d exp=10", pkt0); end
  endtask

  task automatic test_full();
    logic [9:0] exp;
    b0.req_valid_i   = 4'b0011;
    b0.req_last_i    = 4'b0010;
    b0.req_data_i[1] = 8'h11;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        b0.fifo_full_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk_wr);
          checks++; if (b0.fifo_wr_en_o !== 1'b0 || b0.req_ready_o !== 4'b0000 || busy0 !== 1'b1) begin errors++; $display("FAIL full_hold%0d got=%b/%b/%b exp=0/0000/1", c, b0.fifo_wr_en_o, b0.req_ready_o, busy0); end
          step();
        end
        b0.fifo_full_i = 1'b0;
      end
      b0.req_data_i[0] = 8'(192 + b);
      b0.req_last_i[0] = (b == 3);
      exp = {2'd0, 8'(192 + b)};
      @(negedge clk_wr);
      checks++; if (b0.fifo_wr_en_o !== 1'b1 || b0.fifo_wr_data_o !== exp || b0.req_ready_o !== 4'b0001) begin errors++; $display("FAIL full_beat%0d got=%b/%h/%b exp=1/%h/0001", b, b0.fifo_wr_en_o, b0.fifo_wr_data_o, b0.req_ready_o, exp); end
      step();
    end
    b0.req_valid_i = 4'b0010;
    @(negedge clk_wr);
    checks++; if (b0.fifo_wr_en_o !== 1'b1 || b0.fifo_wr_data_o !== {2'd1, 8'h11}) begin errors++; $display("FAIL full_next_req1 got=%b/%h exp=1/111", b0.fifo_wr_en_o, b0.fifo_wr_data_o); end
    step();
    b0.req_valid_i = 4'b0000;
    checks++; if (pkt0 !== 16'd12) begin errors++; $display("FAIL full_pkt got=%0d exp=12", pkt0); end
  endtask

  task automatic test_burst_limit();
    logic [1:0] seq [7] = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3};
    logic [9:0] exp;
    int         r = 0;
    b1.req_valid_i   = 4'b0100;
    b1.req_last_i    = 4'b0100;
    b1.req_data_i[2] = 8'h55;
    @(negedge clk_wr);
    checks++; if (b1.fifo_wr_en_o !== 1'b1 || b1.fifo_wr_data_o !== {2'd2, 8'h55}) begin errors++; $display("FAIL burst_setup got=%b/%h exp=1/255", b1.fifo_wr_en_o, b1.fifo_wr_data_o); end
    step();
    b1.req_valid_i   = 4'b1001;
    b1.req_last_i[0] = 1'b1;
    b1.req_data_i[0] = 8'h0F;
    for (int c = 0; c < 7; c++) begin
      b1.req_data_i[3] = 8'(48 + r);
      b1.req_last_i[3] = (r == 4);
      exp = (seq[c] == 2'd3) ? {2'd3, 8'(48 + r)} : {2'd0, 8'h0F};
      @(negedge clk_wr);
      checks++; if (b1.fifo_wr_en_o !== 1'b1 || b1.fifo_wr_data_o !== exp) begin errors++; $display("FAIL burst_seq%0d got=%b/%h exp=1/%h", c, b1.fifo_wr_en_o, b1.fifo_wr_data_o, exp); end
      step();
      if (seq[c] == 2'd3) r++;
    end
    b1.req_valid_i = 4'b0000;
    checks++; if (pkt1 !== 16'd4 || busy1 !== 1'b0) begin errors++; $display("FAIL burst_pkt got=%0d/%b exp=4/0", pkt1, busy1); end
  endtask

  task automatic test_reset_mid_packet();
    b0.req_valid_i   = 4'b0100;
    b0.req_last_i    = 4'b0000;
    b0.req_data_i[0] = 8'h01;
    b0.req_data_i[2] = 8'h77;
    @(negedge clk_wr);
    checks++; if (b0.fifo_wr_data_o !== {2'd2, 8'h77} || b0.fifo_wr_en_o !== 1'b1) begin errors++; $display("FAIL rstmid_start got=%b/%h exp=1/277", b0.fifo_wr_en_o, b0.fifo_wr_data_o); end
    step();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_locked got=%b exp=1", busy0); end
    b0.req_valid_i = 4'b0111;
    b0.req_last_i  = 4'b1111;
    arst_wr = 1'b1;
    #1;
    checks++; if (busy0 !== 1'b0 || pkt0 !== 16'd0) begin errors++; $display("FAIL rstmid_clear got=%b/%0d exp=0/0", busy0, pkt0); end
    checks++; if (b0.req_ready_o !== 4'b0000 || b0.fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready got=%b/%b exp=0000/0", b0.req_ready_o, b0.fifo_wr_en_o); end
    step();
    arst_wr = 1'b0;
    @(negedge clk_wr);
    checks++; if (b0.fifo_wr_en_o !== 1'b1 || b0.fifo_wr_data_o !== {2'd0, 8'h01}) begin errors++; $display("FAIL rstmid_regrant got=%b/%h exp=1/001", b0.fifo_wr_en_o, b0.fifo_wr_data_o); end
    step();
    b0.req_valid_i = 4'b0000;
    checks++; if (pkt0 !== 16'd1 || grant0 !== 2'd0) begin errors++; $display("FAIL rstmid_pkt got=%0d/%0d exp=1/0", pkt0, grant0); end
  endtask

  initial begin
    b0.req_valid_i = '0; b0.req_data_i = '0; b0.req_last_i = '0; b0.fifo_full_i = 1'b0;
    b1.req_valid_i = '0; b1.req_data_i = '0; b1.req_last_i = '0; b1.fifo_full_i = 1'b0;
    #1;
    test_reset();
    test_round_robin();
    test_locked();
    test_full();
    test_burst_limit();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
